// File: rtl/fp_reciprocal_sequencer_if.sv
// Request/response bundle between the divider control and the reciprocal sequencer.
interface fp_reciprocal_sequencer_if;
    logic        start;
    logic [31:0] operand;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        div_by_zero;
    logic        invalid;

    modport master (
        output start,
        output operand,
        input  busy,
        input  done,
        input  result,
        input  div_by_zero,
        input  invalid
    );

    modport slave (
        input  start,
        input  operand,
        output busy,
        output done,
        output result,
        output div_by_zero,
        output invalid
    );
endinterface

// File: rtl/fp_reciprocal_sequencer.sv
// Single-precision reciprocal: linear seed, Newton-Raphson refinement on one shared
// 24x32 multiplier, then pack/round with special-case handling.
module fp_reciprocal_sequencer #(
    parameter int unsigned ITERATIONS = 3
) (
    input  logic                             clk,
    input  logic                             rst,
    fp_reciprocal_sequencer_if.slave         bus
);
    // 24/17 and 8/17 rounded to Q1.31
    localparam logic [31:0] SeedC1   = 32'hB4B4_B4B5;
    localparam logic [31:0] SeedC2   = 32'h3C3C_3C3C;
    localparam logic [2:0]  LastIter = 3'(ITERATIONS - 1);

    typedef enum logic [2:0] {StIdle, StSeed, StMul1, StMul2, StPack} state_e;

    state_e      state_q;
    logic        sign_q;
    logic [7:0]  exp_q;
    logic [22:0] man_q;
    logic [31:0] x_q;
    logic [31:0] e2_q;
    logic [2:0]  iter_q;
    logic        busy_q;
    logic        done_q;
    logic        dbz_q;
    logic        inv_q;
    logic [31:0] result_q;

    logic [23:0] mul_a;
    logic [31:0] mul_b;
    logic [55:0] mul_p;
    logic [31:0] mul_hi;
    logic [31:0] corr;
    logic [31:0] delta;
    logic [31:0] delta_mag;
    logic        delta_neg;

    // E2 sits close to 1, so X*E2 is formed as X + X*(E2-1); this keeps the 24-bit
    // multiplier operand at full precision instead of truncating E2 itself.
    always_comb begin
        delta     = e2_q - 32'h8000_0000;
        delta_neg = delta[31];
        delta_mag = delta_neg ? (32'd0 - delta) : delta;
        mul_a     = {1'b1, man_q};
        mul_b     = x_q;
        case (state_q)
            StSeed:  mul_b = SeedC2;
            StMul2:  mul_a = delta_mag[26:3];
            default: ;
        endcase
        mul_p  = {32'd0, mul_a} * {24'd0, mul_b};
        mul_hi = mul_p[54:23];
        corr   = {4'd0, mul_p[55:28]};
    end

    logic [31:0] pk_result;
    logic        pk_dbz;
    logic        pk_inv;
    logic [23:0] rnd;
    logic [9:0]  exp_pow;
    logic [9:0]  exp_rnd;

    always_comb begin
        pk_result = 32'h0;
        pk_dbz    = 1'b0;
        pk_inv    = 1'b0;
        rnd       = {1'b0, x_q[29:7]} + {23'd0, x_q[6]};
        exp_pow   = 10'd254 - {2'b00, exp_q};
        exp_rnd   = 10'd253 - {2'b00, exp_q} + {9'd0, rnd[23]};
        if (exp_q == 8'd0) begin
            pk_result = {sign_q, 8'hFF, 23'd0};
            pk_dbz    = 1'b1;
        end else if (exp_q == 8'hFF) begin
            if (man_q == 23'd0) begin
                pk_result = {sign_q, 31'd0};
            end else begin
                pk_result = 32'h7FC0_0000;
                pk_inv    = 1'b1;
            end
        end else if (man_q == 23'd0) begin
            pk_result = (exp_pow == 10'd0) ? {sign_q, 31'd0} : {sign_q, exp_pow[7:0], 23'd0};
        end else if (exp_rnd[9] || exp_rnd == 10'd0) begin
            pk_result = {sign_q, 31'd0};
        end else begin
            pk_result = {sign_q, exp_rnd[7:0], rnd[22:0]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            sign_q   <= 1'b0;
            exp_q    <= 8'd0;
            man_q    <= 23'd0;
            x_q      <= 32'd0;
            e2_q     <= 32'd0;
            iter_q   <= 3'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
            inv_q    <= 1'b0;
            result_q <= 32'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        sign_q  <= bus.operand[31];
                        exp_q   <= bus.operand[30:23];
                        man_q   <= bus.operand[22:0];
                        busy_q  <= 1'b1;
                        state_q <= StSeed;
                    end
                end
                StSeed: begin
                    x_q     <= SeedC1 - mul_hi;
                    iter_q  <= 3'd0;
                    state_q <= StMul1;
                end
                StMul1: begin
                    e2_q    <= 32'd0 - mul_hi;
                    state_q <= StMul2;
                end
                StMul2: begin
                    x_q     <= delta_neg ? (x_q - corr) : (x_q + corr);
                    iter_q  <= iter_q + 3'd1;
                    state_q <= (iter_q < LastIter) ? StMul1 : StPack;
                end
                StPack: begin
                    result_q <= pk_result;
                    dbz_q    <= pk_dbz;
                    inv_q    <= pk_inv;
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.result      = result_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.invalid     = inv_q;

    logic unused_bits;
    assign unused_bits = ^{delta_mag[31:27], delta_mag[2:0], mul_p[22:0]};
endmodule
